// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants and FSM encoding for the PWM duty meter.
// PWM_GLITCH_FILTER_EN enables the input glitch filter (FILT_LEN_DEF samples).
package pwm_duty_meter_pkg;

  localparam int unsigned CNT_W_DEF       = 20;
  localparam int unsigned TIMEOUT_MAX_DEF = 1000000;
  localparam int unsigned FILT_LEN_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises the PWM pin and produces registered rise/fall pulses plus the aligned level.
// With PWM_GLITCH_FILTER_EN a level is accepted only after FILT_LEN equal samples.
module pwm_edge_sync
`ifdef PWM_GLITCH_FILTER_EN
  import pwm_duty_meter_pkg::*;
  #(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
  )
`endif
  (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q;
  logic prev_q, rise_q, fall_q;
  logic level_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pwm_i;
      sync_q <= meta_q;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILT_LEN + 1);

  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Count consecutive samples disagreeing with the accepted level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) begin
        filt_d = sync_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level_c = filt_q;
`else
  assign level_c = sync_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level_c;
      rise_q <= level_c & ~prev_q;
      fall_q <= ~level_c & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an external PWM input; flags a stuck input.
// Optional glitch filter selected by PWM_GLITCH_FILTER_EN.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_MAX = TIMEOUT_MAX_DEF
`ifdef PWM_GLITCH_FILTER_EN
  , parameter int unsigned FILT_LEN  = FILT_LEN_DEF
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             sat,
  output logic             stuck,
  output logic             stuck_level
);

  localparam int unsigned      TO_W    = $clog2(TIMEOUT_MAX);
  localparam logic [TO_W-1:0]  TO_TERM = TO_W'(TIMEOUT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic level, rise, fall;

  pwm_edge_sync
`ifdef PWM_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_edge (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .pwm_i   (pwm_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d, sat_q, sat_d;
  logic             stuck_q, stuck_d, stuck_level_q, stuck_level_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic             timeout_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Next state: an edge always wins over the timeout terminal count.
  always_comb begin
    state_d       = state_q;
    per_d         = per_q;
    hi_d          = hi_q;
    hi_lat_d      = hi_lat_q;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    meas_valid_d  = 1'b0;
    sat_d         = sat_q;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    idle_d        = idle_q;
    timeout_c     = (idle_q == TO_TERM) && !rise && !fall;

    if (rise || fall) begin
      idle_d = '0;
    end else if (idle_q != TO_TERM) begin
      idle_d = idle_q + TO_W'(1);
    end

    if (timeout_c) begin
      stuck_d       = 1'b1;
      stuck_level_d = level;
      state_d       = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            per_d   = CNT_W'(1);
            hi_d    = CNT_W'(1);
            stuck_d = 1'b0;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          per_d = sat_inc(per_q);
          hi_d  = sat_inc(hi_q);
          if (fall) begin
            hi_lat_d = hi_q;
            state_d  = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_cnt_d   = hi_lat_q;
            period_cnt_d = per_q;
            sat_d        = (per_q == CNT_MAX) || (hi_lat_q == CNT_MAX);
            meas_valid_d = 1'b1;
            per_d        = CNT_W'(1);
            hi_d         = CNT_W'(1);
            stuck_d      = 1'b0;
            state_d      = ST_HIGH;
          end else begin
            per_d = sat_inc(per_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      per_q         <= '0;
      hi_q          <= '0;
      hi_lat_q      <= '0;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      meas_valid_q  <= 1'b0;
      sat_q         <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
      idle_q        <= '0;
    end else begin
      state_q       <= state_d;
      per_q         <= per_d;
      hi_q          <= hi_d;
      hi_lat_q      <= hi_lat_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      meas_valid_q  <= meas_valid_d;
      sat_q         <= sat_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
      idle_q        <= idle_d;
    end
  end

  assign high_cnt    = high_cnt_q;
  assign period_cnt  = period_cnt_q;
  assign meas_valid  = meas_valid_q;
  assign sat         = sat_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter (default build, no glitch filter): a 20-bit and an 8-bit
// instance share one PWM stimulus and are checked every cycle against a period-level model.
module tb_pwm_duty_meter;

  localparam int TMAX = 1000;
  localparam int W0   = 20;
  localparam int W1   = 8;
  localparam int LAT  = 3;
  localparam int HMAX = 20000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic pwm_in    = 1'b0;

  logic [W0-1:0] hi0, per0;
  logic [W1-1:0] hi1, per1;
  logic          v0, s0, st0, sl0, v1, s1, st1, sl1;

  pwm_duty_meter #(.CNT_W(W0), .TIMEOUT_MAX(TMAX)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_in),
    .high_cnt(hi0), .period_cnt(per0), .meas_valid(v0), .sat(s0),
    .stuck(st0), .stuck_level(sl0)
  );

  pwm_duty_meter #(.CNT_W(W1), .TIMEOUT_MAX(TMAX)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_in),
    .high_cnt(hi1), .period_cnt(per1), .meas_valid(v1), .sat(s1),
    .stuck(st1), .stuck_level(sl1)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pin samples per cycle; a transition sampled at cycle i acts at cycle i+LAT.
  bit hist [0:HMAX];
  int cyc = 0, phase = 0, rise_c = 0, fall_c = 0, last_edge = 0;
  bit cur_b, prv_b;
  bit m_valid = 1'b0, m_stuck = 1'b0, m_lvl = 1'b0;
  int m_hi [2];
  int m_per[2];
  bit m_sat[2];
  int maxv [2];

  function automatic bit get_pin(input int i);
    return (i <= 0) ? 1'b0 : hist[i];
  endfunction

  function automatic int clip(input int v, input int m);
    return (v >= m) ? m : v;
  endfunction

  initial begin
    maxv[0] = (1 << W0) - 1;
    maxv[1] = (1 << W1) - 1;
    for (int k = 0; k < 2; k++) begin
      m_hi[k] = 0; m_per[k] = 0; m_sat[k] = 1'b0;
    end
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        cyc = 0; phase = 0; rise_c = 0; fall_c = 0; last_edge = 0;
        m_valid = 1'b0; m_stuck = 1'b0; m_lvl = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_hi[k] = 0; m_per[k] = 0; m_sat[k] = 1'b0;
        end
      end else begin
        cyc++;
        if (cyc <= HMAX) hist[cyc] = pwm_in;
        cur_b   = get_pin(cyc - LAT);
        prv_b   = get_pin(cyc - LAT - 1);
        m_valid = 1'b0;
        if (cur_b != prv_b) begin
          last_edge = cyc;
          if (cur_b) begin
            if (phase == 2) begin
              m_valid = 1'b1;
              for (int k = 0; k < 2; k++) begin
                m_per[k] = clip(cyc - rise_c, maxv[k]);
                m_hi[k]  = clip(fall_c - rise_c, maxv[k]);
                m_sat[k] = (m_per[k] == maxv[k]) || (m_hi[k] == maxv[k]);
              end
            end
            phase   = 1;
            rise_c  = cyc;
            m_stuck = 1'b0;
          end else if (phase == 1) begin
            phase  = 2;
            fall_c = cyc;
          end
        end else if (cyc - last_edge >= TMAX) begin
          m_stuck = 1'b1;
          m_lvl   = cur_b;
          phase   = 0;
        end
      end
    end
  end

  int pub_hi[$];
  int pub_per[$];

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge sys_clk);
      chk("dut0.high_cnt",    int'(hi0),  m_hi[0]);
      chk("dut0.period_cnt",  int'(per0), m_per[0]);
      chk("dut0.meas_valid",  int'(v0),   int'(m_valid));
      chk("dut0.sat",         int'(s0),   int'(m_sat[0]));
      chk("dut0.stuck",       int'(st0),  int'(m_stuck));
      chk("dut0.stuck_level", int'(sl0),  int'(m_lvl));
      chk("dut1.high_cnt",    int'(hi1),  m_hi[1]);
      chk("dut1.period_cnt",  int'(per1), m_per[1]);
      chk("dut1.meas_valid",  int'(v1),   int'(m_valid));
      chk("dut1.sat",         int'(s1),   int'(m_sat[1]));
      chk("dut1.stuck",       int'(st1),  int'(m_stuck));
      chk("dut1.stuck_level", int'(sl1),  int'(m_lvl));
      if (v0) begin
        pub_hi.push_back(int'(hi0));
        pub_per.push_back(int'(per0));
      end
    end
  end

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic pwm_cycles(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic clear_pubs();
    pub_hi.delete();
    pub_per.delete();
  endtask

  task automatic chk_pub(input string name, input int idx, input int h, input int p);
    if (idx < pub_hi.size()) begin
      chk({name, "_hi"},  pub_hi[idx],  h);
      chk({name, "_per"}, pub_per[idx], p);
    end else begin
      chk({name, "_count"}, pub_hi.size(), idx + 1);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_high"},   int'(hi0),  0);
    chk({name, "_period"}, int'(per0), 0);
    chk({name, "_valid"},  int'(v0),   0);
    chk({name, "_stuck"},  int'(st0),  0);
    chk({name, "_sat"},    int'(s0),   0);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    chk_zero("reset");
    sys_rst_n = 1'b1;

    // Held low from reset: stuck at the terminal count, level 0, no result.
    drive(1'b0, 990);
    chk("stuck_early", int'(st0), 0);
    drive(1'b0, 20);
    chk("stuck_low", int'(st0), 1);
    chk("stuck_level_low", int'(sl0), 0);
    chk("stuck_low_no_valid", pub_hi.size(), 0);

    // 30/100 for five periods plus a closing rise.
    clear_pubs();
    pwm_cycles(30, 70, 5);
    drive(1'b1, 30);
    drive(1'b0, 10);
    chk("p30_count", pub_hi.size(), 5);
    chk_pub("p30_first", 0, 30, 100);
    chk_pub("p30_last", 4, 30, 100);
    chk("p30_stuck_cleared", int'(st0), 0);
    chk("p30_dut1_period", int'(per1), 100);
    chk("p30_dut1_sat", int'(s1), 0);

    // 99 high / 1 low.
    clear_pubs();
    pwm_cycles(99, 1, 3);
    drive(1'b1, 5);
    chk("p99_count", pub_hi.size(), 4);
    chk_pub("p99_transition", 0, 30, 40);
    chk_pub("p99_last", 3, 99, 100);

    // 50/100 then stuck high; outputs hold, a rise clears stuck.
    clear_pubs();
    drive(1'b0, 45);
    pwm_cycles(50, 50, 3);
    drive(1'b1, 1100);
    chk("hold_count", pub_hi.size(), 4);
    chk_pub("hold_first", 0, 5, 50);
    chk("stuck_high", int'(st0), 1);
    chk("stuck_level_high", int'(sl0), 1);
    chk("stuck_hold_high_cnt", int'(hi0), 50);
    chk("stuck_hold_period_cnt", int'(per0), 100);
    drive(1'b0, 20);
    chk("stuck_after_fall", int'(st0), 1);
    drive(1'b1, 30);
    chk("stuck_after_rise", int'(st0), 0);
    chk("stuck_rise_no_valid", pub_hi.size(), 4);

    // 2-cycle low glitch inside a 40-cycle high phase.
    clear_pubs();
    drive(1'b0, 70);
    drive(1'b1, 40);
    drive(1'b0, 60);
    drive(1'b1, 15);
    drive(1'b0, 2);
    drive(1'b1, 23);
    drive(1'b0, 60);
    drive(1'b1, 40);
    drive(1'b0, 60);
    drive(1'b1, 5);
    chk("glitch_count", pub_hi.size(), 5);
    chk_pub("glitch_pre", 1, 40, 100);
    chk_pub("glitch_short", 2, 15, 17);
    chk_pub("glitch_rest", 3, 23, 83);
    chk_pub("glitch_after", 4, 40, 100);

    // Reset in the middle of a high phase.
    drive(1'b1, 20);
    sys_rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    clear_pubs();
    drive(1'b1, 10);
    drive(1'b0, 50);
    chk("midreset_no_early_valid", pub_hi.size(), 0);
    drive(1'b1, 30);
    chk_pub("midreset_first", 0, 10, 60);
    drive(1'b0, 70);
    drive(1'b1, 5);
    chk_pub("midreset_second", 1, 30, 100);

    // Period 300: saturates the 8-bit instance only.
    clear_pubs();
    drive(1'b0, 295);
    pwm_cycles(30, 270, 2);
    drive(1'b1, 5);
    chk_pub("p300_first", 0, 5, 300);
    chk("p300_dut0_period", int'(per0), 300);
    chk("p300_dut0_high", int'(hi0), 30);
    chk("p300_dut0_sat", int'(s0), 0);
    chk("p300_dut1_period", int'(per1), 255);
    chk("p300_dut1_high", int'(hi1), 30);
    chk("p300_dut1_sat", int'(s1), 1);

    drive(1'b0, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
